loop_mem_ctrl: RTL and testbench

- Downstream of the looper record/play state machine. Consumes its rec_en and play_en levels and returns the rec_done pulse that ends a recording when the buffer fills.
- Owns the loop sample memory port: write address/enable while recording, read address/enable while playing.
- Tracks loop length and wraps playback seamlessly at the loop end.
- Sample cadence is set by an external one-cycle sample_tick strobe.

---
 rtl/loop_pkg.sv | 17 +
 rtl/loop_ptr.sv | 25 ++
 rtl/loop_mem_ctrl.sv | 154 +++++++++++++++
 tb/tb_loop_mem_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/loop_pkg.sv
// Shared types and defaults for the looper memory controller and its
// record/play FSM.
package loop_pkg;

  localparam int LOOP_ADDR_W = 14;
  localparam int LOOP_DATA_W = 8;
  // Tick to play_valid latency: one cycle to issue the read, one for RAM.
  localparam int PLAY_LAT    = 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REC,
    S_FULL,
    S_PLAY
  } mem_state_t;

endpackage

// File: rtl/loop_ptr.sv
// Wrapping up-counter: clears to 0, increments, and returns to 0 once
// ptr+1 reaches limit.
module loop_ptr #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W:0]   limit,
  output logic [W-1:0] ptr
);

  logic [W:0] nxt;

  // Compare at W+1 bits so a limit of 2**W is reachable.
  assign nxt = {1'b0, ptr} + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= (nxt == limit) ? '0 : nxt[W-1:0];
  end

endmodule

// File: rtl/loop_mem_ctrl.sv
// Loop sample memory controller: records ticks into RAM, plays the
// recorded loop back with seamless wrap at loop end.
module loop_mem_ctrl
  import loop_pkg::*;
#(
  parameter int ADDR_W = LOOP_ADDR_W,
  parameter int DATA_W = LOOP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_en,
  input  logic              play_en,
  input  logic              sample_tick,
  input  logic [DATA_W-1:0] sample_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] play_data,
  output logic              play_valid,
  output logic              rec_done,
  output logic [ADDR_W:0]   loop_len,
  output logic              have_loop
);

  localparam int STAGES = PLAY_LAT - 1;
  localparam logic [ADDR_W:0]   DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] LAST  = '1;

  mem_state_t state_q, state_d;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              wr_clr, rd_clr, len_clr;
  logic              do_write, do_read, do_silent;
  logic              busy, tick_ok;
  logic [STAGES:0]   vld_pipe, rd_pipe;
  logic [DATA_W-1:0] play_hold;

  assign have_loop = (loop_len != '0);
  // Any access still in flight swallows a new tick.
  assign busy      = mem_we | (|vld_pipe);
  assign tick_ok   = sample_tick & ~busy;

  loop_ptr #(.W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wr_clr),
    .inc   (do_write),
    .limit (DEPTH),
    .ptr   (wr_ptr)
  );

  loop_ptr #(.W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rd_clr),
    .inc   (do_read),
    .limit (loop_len),
    .ptr   (rd_ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wr_clr    = 1'b0;
    rd_clr    = 1'b0;
    len_clr   = 1'b0;
    do_write  = 1'b0;
    do_read   = 1'b0;
    do_silent = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rec_en) begin
          state_d = S_REC;
          wr_clr  = 1'b1;
          len_clr = 1'b1;
        end else if (play_en) begin
          state_d = S_PLAY;
          rd_clr  = 1'b1;
        end
      end
      S_REC: begin
        if (!rec_en) begin
          state_d = play_en ? S_PLAY : S_IDLE;
          rd_clr  = 1'b1;
        end else if (tick_ok) begin
          do_write = 1'b1;
          if (wr_ptr == LAST) state_d = S_FULL;
        end
      end
      // Holds off until the FSM, one cycle behind rec_done, drops rec_en.
      S_FULL: begin
        if (!rec_en) begin
          state_d = play_en ? S_PLAY : S_IDLE;
          rd_clr  = 1'b1;
        end
      end
      S_PLAY: begin
        if (rec_en) begin
          state_d = S_REC;
          wr_clr  = 1'b1;
          len_clr = 1'b1;
        end else if (!play_en) begin
          state_d = S_IDLE;
        end else if (tick_ok) begin
          do_read   = have_loop;
          do_silent = ~have_loop;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      rec_done  <= 1'b0;
      loop_len  <= '0;
      vld_pipe  <= '0;
      rd_pipe   <= '0;
      play_hold <= '0;
    end else begin
      mem_we   <= do_write;
      mem_re   <= do_read;
      rec_done <= do_write && (wr_ptr == LAST);
      if (do_write) begin
        mem_addr  <= wr_ptr;
        mem_wdata <= sample_in;
        loop_len  <= {1'b0, wr_ptr} + 1'b1;
      end else if (do_read) begin
        mem_addr <= rd_ptr;
      end
      if (len_clr) loop_len <= '0;
      // Pipe keeps shifting after play ends so an in-flight read completes.
      vld_pipe <= {vld_pipe[STAGES-1:0], do_read | do_silent};
      rd_pipe  <= {rd_pipe[STAGES-1:0], do_read};
      if (vld_pipe[STAGES]) play_hold <= play_data;
    end
  end

  // RAM data is live in the valid cycle; the hold register covers the rest.
  assign play_data  = vld_pipe[STAGES] ? (rd_pipe[STAGES] ? mem_rdata : '0)
                                       : play_hold;
  assign play_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_loop_mem_ctrl.sv
// Directed plus randomized bench for loop_mem_ctrl against a behavioural
// loop model (ADDR_W=3, ticks every 4 cycles).
module tb_loop_mem_ctrl;

  localparam int AW    = 3;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rec_en, play_en, sample_tick;
  logic [DW-1:0] sample_in;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic [DW-1:0] play_data;
  logic          play_valid, rec_done, have_loop;
  logic [AW:0]   loop_len;

  loop_mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rec_en      (rec_en),
    .play_en     (play_en),
    .sample_tick (sample_tick),
    .sample_in   (sample_in),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_re      (mem_re),
    .mem_rdata   (mem_rdata),
    .play_data   (play_data),
    .play_valid  (play_valid),
    .rec_done    (rec_done),
    .loop_len    (loop_len),
    .have_loop   (have_loop)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after mem_re.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  // Behavioural model of the loop
  typedef enum {M_IDLE, M_REC, M_FULL, M_PLAY} mmode_t;
  mmode_t        mode;
  logic [DW-1:0] m_mem [DEPTH];
  int            m_len, m_wr, m_rd;
  logic [DW-1:0] m_last;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mode   = M_IDLE;
    m_len  = 0;
    m_last = '0;
  endtask

  task automatic set_en(input logic r, input logic p);
    @(negedge clk);
    rec_en  = r;
    play_en = p;
    case (mode)
      M_IDLE: if (r) begin mode = M_REC; m_wr = 0; m_len = 0; end
              else if (p) begin mode = M_PLAY; m_rd = 0; end
      M_REC, M_FULL: if (!r) begin mode = p ? M_PLAY : M_IDLE; m_rd = 0; end
      M_PLAY: if (r) begin mode = M_REC; m_wr = 0; m_len = 0; end
              else if (!p) mode = M_IDLE;
      default: ;
    endcase
    @(negedge clk);
    chk("len_after_en", 32'(loop_len), 32'(m_len));
  endtask

  // One sample period: tick, then 3 quiet cycles, checking each phase.
  task automatic tick(input logic [DW-1:0] s);
    logic e_we, e_re, e_done, e_vld;
    int   e_addr;
    logic [DW-1:0] e_pd;
    e_we = 0; e_re = 0; e_done = 0; e_vld = 0; e_addr = 0; e_pd = m_last;
    case (mode)
      M_REC: begin
        e_we = 1; e_addr = m_wr; m_mem[m_wr] = s;
        m_len = m_wr + 1;
        e_done = (m_wr == DEPTH - 1);
        m_wr = m_wr + 1;
        if (e_done) mode = M_FULL;
      end
      M_PLAY: begin
        e_vld = 1;
        if (m_len != 0) begin
          e_re = 1; e_addr = m_rd; e_pd = m_mem[m_rd];
          m_rd = (m_rd + 1) % m_len;
        end else e_pd = '0;
        m_last = e_pd;
      end
      default: ;
    endcase
    @(negedge clk);
    sample_tick = 1'b1;
    sample_in   = s;
    @(negedge clk);
    sample_tick = 1'b0;
    sample_in   = DW'($urandom);
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_re", 32'(mem_re), 32'(e_re));
    chk("rec_done", 32'(rec_done), 32'(e_done));
    if (e_we) begin
      chk("wr_addr", 32'(mem_addr), 32'(e_addr));
      chk("wr_data", 32'(mem_wdata), 32'(s));
    end
    if (e_re) chk("rd_addr", 32'(mem_addr), 32'(e_addr));
    chk("valid_early", 32'(play_valid), 32'(0));
    @(negedge clk);
    chk("play_valid", 32'(play_valid), 32'(e_vld));
    chk("play_data", 32'(play_data), 32'(e_pd));
    chk("strobes_off", 32'({mem_we, mem_re, rec_done}), 32'(0));
    @(negedge clk);
    chk("valid_late", 32'(play_valid), 32'(0));
    chk("play_hold", 32'(play_data), 32'(m_last));
    chk("loop_len", 32'(loop_len), 32'(m_len));
    chk("have_loop", 32'(have_loop), 32'(m_len != 0));
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({mem_addr, mem_we, mem_wdata, mem_re, play_data,
                  play_valid, rec_done, loop_len, have_loop}), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rec_en = 1'b0; play_en = 1'b0;
    sample_tick = 1'b0; sample_in = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_all_zero("reset_state");
    rst_n = 1'b1;

    // Async reset in the middle of a record write
    set_en(1, 0);
    repeat (3) tick(DW'($urandom));
    @(negedge clk);
    sample_tick = 1'b1; sample_in = 8'hA5;
    @(negedge clk);
    sample_tick = 1'b0;
    chk("pre_reset_we", 32'(mem_we), 32'(1));
    #2 rst_n = 1'b0; rec_en = 1'b0;
    #1 chk_all_zero("async_reset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("len_after_reset", 32'(loop_len), 32'(0));

    // Empty play emits silence
    set_en(0, 1);
    repeat (3) tick(DW'($urandom));
    set_en(0, 0);

    // Short record
    set_en(1, 0);
    for (int i = 0; i < 5; i++) tick(DW'(8'h11 + i));
    set_en(0, 0);
    chk("short_len", 32'(loop_len), 32'(5));
    chk("short_have", 32'(have_loop), 32'(1));

    // Play with wrap, then idle hold
    set_en(0, 1);
    repeat (7) tick(DW'($urandom));
    chk("wrap_last", 32'(play_data), 32'(8'h12));
    set_en(0, 0);
    tick(DW'($urandom));

    // Play-to-record, continuing into a full record
    set_en(0, 1);
    repeat (2) tick(DW'($urandom));
    set_en(1, 1);
    chk("p2r_len0", 32'(loop_len), 32'(0));
    tick(DW'($urandom));
    chk("p2r_len1", 32'(loop_len), 32'(1));
    repeat (9) tick(DW'($urandom));
    chk("full_len", 32'(loop_len), 32'(DEPTH));
    set_en(0, 1);
    repeat (10) tick(DW'($urandom));

    // Random mix of enables and ticks
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 3) == 0) set_en(1'($urandom), 1'($urandom));
      else tick(DW'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
